// File: rtl/padctl_filt.sv
// padctl_filt: NumPads bidirectional pad controller with a 2-flop input sync, per-pad glitch filter,
// software output override and a single-cycle register port. PADCTL_FILT_EVENT_EN builds edge/EVENT/irq.
module padctl_filt #(
    parameter int unsigned NumPads  = 16,
    parameter int unsigned FiltCntW = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumPads-1:0] pad_in_i,
    output logic [NumPads-1:0] pad_out_o,
    output logic [NumPads-1:0] pad_oe_o,
    output logic [NumPads-1:0] core_in_o,
    input  logic [NumPads-1:0] core_out_i,
    input  logic [NumPads-1:0] core_oe_i,
    output logic [NumPads-1:0] rise_o,
    output logic [NumPads-1:0] fall_o,
    output logic               irq_o,
    input  logic               reg_req_i,
    input  logic               reg_we_i,
    input  logic [2:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o,
    output logic               reg_ack_o
);

    localparam logic [2:0] ADDR_FILT_EN  = 3'd0;
    localparam logic [2:0] ADDR_THRESH   = 3'd1;
    localparam logic [2:0] ADDR_OVRD_EN  = 3'd2;
    localparam logic [2:0] ADDR_OVRD_VAL = 3'd3;
    localparam logic [2:0] ADDR_PAD_IN   = 3'd4;
    localparam logic [2:0] ADDR_EVENT    = 3'd5;

    logic [NumPads-1:0]  filt_en_q,  filt_en_d;
    logic [FiltCntW-1:0] thresh_q,   thresh_d;
    logic [NumPads-1:0]  ovrd_en_q,  ovrd_en_d;
    logic [NumPads-1:0]  ovrd_val_q, ovrd_val_d;
    logic [NumPads-1:0]  sync1_q,    sync1_d;
    logic [NumPads-1:0]  sync_q,     sync_d;
    logic [NumPads-1:0]  pad_out_q,  pad_out_d;
    logic [NumPads-1:0]  pad_oe_q,   pad_oe_d;
    logic                ack_q,      ack_d;
    logic [31:0]         rdata_q,    rdata_d;
    logic [31:0]         rd_mux;
    logic [NumPads-1:0]  event_rd;
    logic [FiltCntW-1:0] thresh_m1;
    logic                wr_en;
    logic [NumPads-1:0]  wr_pads;
    logic                unused_wdata;

    assign wr_en        = reg_req_i & reg_we_i;
    assign wr_pads      = reg_wdata_i[NumPads-1:0];
    assign unused_wdata = ^reg_wdata_i;

    // Configuration registers; writes land on the request edge.
    always_comb begin
        filt_en_d  = filt_en_q;
        thresh_d   = thresh_q;
        ovrd_en_d  = ovrd_en_q;
        ovrd_val_d = ovrd_val_q;
        if (wr_en) begin
            case (reg_addr_i)
                ADDR_FILT_EN:  filt_en_d  = wr_pads;
                ADDR_THRESH:   thresh_d   = reg_wdata_i[FiltCntW-1:0];
                ADDR_OVRD_EN:  ovrd_en_d  = wr_pads;
                ADDR_OVRD_VAL: ovrd_val_d = wr_pads;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr_i)
            ADDR_FILT_EN:  rd_mux[NumPads-1:0]  = filt_en_q;
            ADDR_THRESH:   rd_mux[FiltCntW-1:0] = thresh_q;
            ADDR_OVRD_EN:  rd_mux[NumPads-1:0]  = ovrd_en_q;
            ADDR_OVRD_VAL: rd_mux[NumPads-1:0]  = ovrd_val_q;
            ADDR_PAD_IN:   rd_mux[NumPads-1:0]  = core_in_o;
            ADDR_EVENT:    rd_mux[NumPads-1:0]  = event_rd;
            default: ;
        endcase
    end

    // Sync chain, output path and register-port response.
    always_comb begin
        sync1_d   = pad_in_i;
        sync_d    = sync1_q;
        pad_oe_d  = ovrd_en_q | core_oe_i;
        pad_out_d = (ovrd_en_q & ovrd_val_q) | (~ovrd_en_q & core_out_i);
        ack_d     = reg_req_i;
        rdata_d   = '0;
        if (reg_req_i && !reg_we_i) begin
            rdata_d = rd_mux;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_en_q  <= '0;
            thresh_q   <= '0;
            ovrd_en_q  <= '0;
            ovrd_val_q <= '0;
            sync1_q    <= '0;
            sync_q     <= '0;
            pad_out_q  <= '0;
            pad_oe_q   <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            filt_en_q  <= filt_en_d;
            thresh_q   <= thresh_d;
            ovrd_en_q  <= ovrd_en_d;
            ovrd_val_q <= ovrd_val_d;
            sync1_q    <= sync1_d;
            sync_q     <= sync_d;
            pad_out_q  <= pad_out_d;
            pad_oe_q   <= pad_oe_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
        end
    end

    assign pad_out_o   = pad_out_q;
    assign pad_oe_o    = pad_oe_q;
    assign reg_ack_o   = ack_q;
    assign reg_rdata_o = rdata_q;

    // T=0 acts as T=1; comparing c >= T-1 lets a lowered threshold apply mid-count.
    assign thresh_m1 = (thresh_q == '0) ? '0 : thresh_q - FiltCntW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NumPads; gi++) begin : g_filt
            logic                f_q, f_d;
            logic [FiltCntW-1:0] c_q, c_d;

            always_comb begin
                f_d = f_q;
                c_d = '0;
                if (!filt_en_q[gi]) begin
                    f_d = sync_q[gi];
                end else if (sync_q[gi] != f_q) begin
                    if (c_q >= thresh_m1) begin
                        f_d = sync_q[gi];
                    end else begin
                        c_d = c_q + FiltCntW'(1);
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    f_q <= 1'b0;
                    c_q <= '0;
                end else begin
                    f_q <= f_d;
                    c_q <= c_d;
                end
            end

            assign core_in_o[gi] = f_q;
        end
    endgenerate

`ifdef PADCTL_FILT_EVENT_EN
    logic [NumPads-1:0] f_prev_q, f_prev_d;
    logic [NumPads-1:0] rise_q,   rise_d;
    logic [NumPads-1:0] fall_q,   fall_d;
    logic [NumPads-1:0] event_q,  event_d;

    // A new edge overrides a simultaneous W1C on the same bit.
    always_comb begin
        f_prev_d = core_in_o;
        rise_d   = core_in_o & ~f_prev_q;
        fall_d   = ~core_in_o & f_prev_q;
        event_d  = event_q;
        if (wr_en && (reg_addr_i == ADDR_EVENT)) begin
            event_d = event_q & ~wr_pads;
        end
        event_d = event_d | rise_d | fall_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f_prev_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            event_q  <= '0;
        end else begin
            f_prev_q <= f_prev_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            event_q  <= event_d;
        end
    end

    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign event_rd = event_q;
    assign irq_o    = |event_q;
`else
    assign rise_o   = '0;
    assign fall_o   = '0;
    assign event_rd = '0;
    assign irq_o    = 1'b0;
`endif

endmodule

// File: tb/tb_padctl_filt.sv
// tb_padctl_filt: directed and randomized checks of padctl_filt against a behavioural model
// (sample-history sync, run-length filter, pending-edge events, register file).
module tb_padctl_filt;

    localparam int NP = 16;
    localparam int FW = 8;
`ifdef PADCTL_FILT_EVENT_EN
    localparam bit EvEn = 1'b1;
`else
    localparam bit EvEn = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [NP-1:0] pad_in_i = '0;
    logic [NP-1:0] core_out_i = '0;
    logic [NP-1:0] core_oe_i = '0;
    logic [NP-1:0] pad_out_o, pad_oe_o, core_in_o, rise_o, fall_o;
    logic          irq_o, reg_ack_o;
    logic          reg_req_i = 1'b0;
    logic          reg_we_i = 1'b0;
    logic [2:0]    reg_addr_i = '0;
    logic [31:0]   reg_wdata_i = '0;
    logic [31:0]   reg_rdata_o;

    padctl_filt #(.NumPads(NP), .FiltCntW(FW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pad_in_i(pad_in_i), .pad_out_o(pad_out_o), .pad_oe_o(pad_oe_o),
        .core_in_o(core_in_o), .core_out_i(core_out_i), .core_oe_i(core_oe_i),
        .rise_o(rise_o), .fall_o(fall_o), .irq_o(irq_o),
        .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
        .reg_wdata_i(reg_wdata_i), .reg_rdata_o(reg_rdata_o), .reg_ack_o(reg_ack_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [NP-1:0] samp_q[$];
    logic [NP-1:0] m_f, m_filt_en, m_ovrd_en, m_ovrd_val, m_event;
    logic [NP-1:0] m_pend_rise, m_pend_fall, m_rise, m_fall, m_pad_out, m_pad_oe;
    logic [FW-1:0] m_thresh;
    logic          m_ack;
    logic [31:0]   m_rdata;
    int            run_len[NP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp_q.delete();
        m_f = '0; m_filt_en = '0; m_ovrd_en = '0; m_ovrd_val = '0; m_event = '0;
        m_pend_rise = '0; m_pend_fall = '0; m_rise = '0; m_fall = '0;
        m_pad_out = '0; m_pad_oe = '0; m_thresh = '0; m_ack = 1'b0; m_rdata = '0;
        for (int i = 0; i < NP; i++) run_len[i] = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            3'd0: v[NP-1:0] = m_filt_en;
            3'd1: v[FW-1:0] = m_thresh;
            3'd2: v[NP-1:0] = m_ovrd_en;
            3'd3: v[NP-1:0] = m_ovrd_val;
            3'd4: v[NP-1:0] = m_f;
            3'd5: v[NP-1:0] = EvEn ? m_event : '0;
            default: v = '0;
        endcase
        return v;
    endfunction

    // One clock edge of the model, using the inputs presented before the edge.
    task automatic model_edge();
        logic [NP-1:0] s, f_new, ev_new, w1c, wr;
        int            t_eff;
        bit            wr_en;
        s = (samp_q.size() >= 2) ? samp_q[samp_q.size()-2] : '0;
        samp_q.push_back(pad_in_i);
        if (samp_q.size() > 4) void'(samp_q.pop_front());
        wr_en = reg_req_i && reg_we_i;
        wr = reg_wdata_i[NP-1:0];
        m_ack = reg_req_i;
        m_rdata = (reg_req_i && !reg_we_i) ? m_read(reg_addr_i) : 32'h0;
        m_pad_oe = m_ovrd_en | core_oe_i;
        m_pad_out = (m_ovrd_en & m_ovrd_val) | (~m_ovrd_en & core_out_i);
        t_eff = (m_thresh == '0) ? 1 : int'(m_thresh);
        f_new = m_f;
        for (int i = 0; i < NP; i++) begin
            if (!m_filt_en[i]) begin
                f_new[i] = s[i];
                run_len[i] = 0;
            end else if (s[i] == m_f[i]) begin
                run_len[i] = 0;
            end else begin
                run_len[i]++;
                if (run_len[i] >= t_eff) begin
                    f_new[i] = s[i];
                    run_len[i] = 0;
                end
            end
        end
        w1c = (wr_en && reg_addr_i == 3'd5) ? wr : '0;
        ev_new = (m_event & ~w1c) | m_pend_rise | m_pend_fall;
        m_rise = m_pend_rise;
        m_fall = m_pend_fall;
        m_pend_rise = f_new & ~m_f;
        m_pend_fall = ~f_new & m_f;
        if (wr_en) begin
            case (reg_addr_i)
                3'd0: m_filt_en = wr;
                3'd1: m_thresh = reg_wdata_i[FW-1:0];
                3'd2: m_ovrd_en = wr;
                3'd3: m_ovrd_val = wr;
                default: ;
            endcase
        end
        m_f = f_new;
        m_event = ev_new;
    endtask

    task automatic check_all();
        chk("core_in", 32'(core_in_o), 32'(m_f));
        chk("pad_out", 32'(pad_out_o), 32'(m_pad_out));
        chk("pad_oe", 32'(pad_oe_o), 32'(m_pad_oe));
        chk("rise", 32'(rise_o), EvEn ? 32'(m_rise) : 32'h0);
        chk("fall", 32'(fall_o), EvEn ? 32'(m_fall) : 32'h0);
        chk("irq", 32'(irq_o), EvEn ? 32'(|m_event) : 32'h0);
        chk("ack", 32'(reg_ack_o), 32'(m_ack));
        chk("rdata", reg_rdata_o, m_rdata);
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
        tick();
        reg_req_i = 1'b0; reg_we_i = 1'b0; reg_wdata_i = '0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = a;
        tick();
        d = reg_rdata_o;
        reg_req_i = 1'b0;
    endtask

    // Async reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_pad_oe", 32'(pad_oe_o), 32'h0);
        chk("rst_pad_out", 32'(pad_out_o), 32'h0);
        chk("rst_core_in", 32'(core_in_o), 32'h0);
        chk("rst_rise_fall", 32'(rise_o | fall_o), 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_ack", 32'(reg_ack_o), 32'h0);
        chk("rst_rdata", reg_rdata_o, 32'h0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        model_reset();
        do_reset();

        // Reset values of every address
        for (int a = 0; a < 8; a++) begin
            reg_read(3'(a), d);
            chk($sformatf("rd_reset_a%0d", a), d, 32'h0);
        end

        // Unfiltered rise on pad 3
        pad_in_i[3] = 1'b1;
        tick(); tick();
        chk("unf_core_in3_c2", 32'(core_in_o[3]), 32'h0);
        tick();
        chk("unf_core_in3_c3", 32'(core_in_o[3]), 32'h1);
        tick();
        chk("unf_rise3_c4", 32'(rise_o[3]), EvEn ? 32'h1 : 32'h0);
        reg_read(3'd5, d);
        chk("unf_event", d, EvEn ? 32'h8 : 32'h0);
        reg_write(3'd5, 32'h8);
        reg_read(3'd5, d);
        chk("unf_event_cleared", d, 32'h0);
        chk("unf_irq_cleared", 32'(irq_o), 32'h0);

        // Filter T=5 on pad 0: 4-cycle glitch rejected, long pulse passes after 7 cycles
        reg_write(3'd0, 32'h1);
        reg_write(3'd1, 32'h5);
        pad_in_i[0] = 1'b1;
        repeat (4) tick();
        pad_in_i[0] = 1'b0;
        repeat (12) tick();
        chk("glitch_core_in0", 32'(core_in_o[0]), 32'h0);
        reg_read(3'd5, d);
        chk("glitch_event", d, 32'h0);
        pad_in_i[0] = 1'b1;
        repeat (6) tick();
        chk("pulse_core_in0_c6", 32'(core_in_o[0]), 32'h0);
        tick();
        chk("pulse_core_in0_c7", 32'(core_in_o[0]), 32'h1);
        repeat (3) tick();
        pad_in_i[0] = 1'b0;
        repeat (12) tick();
        chk("pulse_core_in0_end", 32'(core_in_o[0]), 32'h0);

        // Output override
        core_oe_i = '0; core_out_i = '0;
        reg_write(3'd3, 32'h1);
        reg_write(3'd2, 32'h1);
        chk("ovrd_oe_write_edge", 32'(pad_oe_o[0]), 32'h0);
        tick();
        chk("ovrd_oe", 32'(pad_oe_o[0]), 32'h1);
        chk("ovrd_out", 32'(pad_out_o[0]), 32'h1);
        reg_write(3'd2, 32'h0);
        chk("ovrd_oe_held", 32'(pad_oe_o[0]), 32'h1);
        tick();
        chk("ovrd_oe_restored", 32'(pad_oe_o[0]), 32'h0);
        chk("ovrd_out_restored", 32'(pad_out_o[0]), 32'h0);

        // W1C colliding with a new fall on pad 2: set wins
        reg_write(3'd5, 32'hFFFF_FFFF);
        pad_in_i[2] = 1'b1;
        repeat (6) tick();
        pad_in_i[2] = 1'b0;
        repeat (3) tick();
        reg_write(3'd5, 32'h4);
        chk("w1c_collide_irq", 32'(irq_o), EvEn ? 32'h1 : 32'h0);
        reg_read(3'd5, d);
        chk("w1c_collide_event", d, EvEn ? 32'h4 : 32'h0);
        reg_write(3'd5, 32'h4);
        chk("w1c_clear_irq", 32'(irq_o), 32'h0);

        // Reset mid-count with overrides active, then filter restarts from zero
        reg_write(3'd2, 32'h3);
        reg_write(3'd3, 32'h3);
        tick();
        chk("pre_rst_oe", 32'(pad_oe_o[1:0]), 32'h3);
        pad_in_i[0] = 1'b1;
        repeat (4) tick();
        do_reset();
        pad_in_i[0] = 1'b0;
        reg_write(3'd0, 32'h1);
        reg_write(3'd1, 32'h5);
        repeat (3) tick();
        pad_in_i[0] = 1'b1;
        repeat (6) tick();
        chk("restart_core_in0_c6", 32'(core_in_o[0]), 32'h0);
        tick();
        chk("restart_core_in0_c7", 32'(core_in_o[0]), 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 15) == 0) pad_in_i[i] = ~pad_in_i[i];
            end
            core_out_i = NP'($urandom);
            core_oe_i = NP'($urandom);
            if (r < 20) begin
                reg_req_i = 1'b1;
                reg_we_i = 1'($urandom_range(0, 1));
                reg_addr_i = 3'($urandom_range(0, 7));
                reg_wdata_i = (reg_addr_i == 3'd1) ? 32'($urandom_range(0, 7)) : $urandom;
            end else begin
                reg_req_i = 1'b0;
                reg_we_i = 1'b0;
                reg_wdata_i = '0;
            end
            if (n == 700) do_reset();
            tick();
        end
        reg_req_i = 1'b0;
        reg_we_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
